// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with a direct-mapped BTB.
// Lookup is combinational on the pre-edge state; training, BTB fill and
// global-history recovery happen on the rising clock edge.
module gshare_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PHT_IDX_W = 12,
    parameter int unsigned GHR_W     = 8,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned BTB_IDX_W = 6,
    parameter int unsigned BTB_TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    // fetch-side lookup
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    // execute-side resolution
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_is_cond,
    input  logic             upd_taken,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic             mispredict
);

    localparam int unsigned PHT_SIZE = 2 ** PHT_IDX_W;
    localparam int unsigned BTB_SIZE = 2 ** BTB_IDX_W;
    localparam int unsigned TAG_LSB  = BTB_IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]     r_pht [PHT_SIZE];
    logic [BTB_SIZE-1:0]  r_btb_valid;
    logic [BTB_SIZE-1:0]  r_btb_jump;
    logic [BTB_TAG_W-1:0] r_btb_tag    [BTB_SIZE];
    logic [XLEN-1:0]      r_btb_target [BTB_SIZE];
    logic [GHR_W-1:0]     r_ghr;

    logic [PHT_IDX_W-1:0] w_pred_pht_idx;
    logic [BTB_IDX_W-1:0] w_pred_btb_idx;
    logic [BTB_TAG_W-1:0] w_pred_tag;
    logic                 w_btb_hit;

    logic [PHT_IDX_W-1:0] w_upd_pht_idx;
    logic [BTB_IDX_W-1:0] w_upd_btb_idx;
    logic [BTB_TAG_W-1:0] w_upd_tag;
    logic                 w_upd_taken;
    logic [CNT_W-1:0]     w_cnt_cur;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [GHR_W-1:0]     w_ghr_spec;
    logic [GHR_W-1:0]     w_ghr_recover;
    logic                 w_unused_upd_pc;

    // Index/tag extraction; history is zero-extended into the low PHT index bits
    assign w_pred_pht_idx = pred_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
    assign w_pred_btb_idx = pred_pc[BTB_IDX_W+1:2];
    assign w_pred_tag     = pred_pc[TAG_LSB+BTB_TAG_W-1:TAG_LSB];
    assign w_upd_pht_idx  = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
    assign w_upd_btb_idx  = upd_pc[BTB_IDX_W+1:2];
    assign w_upd_tag      = upd_pc[TAG_LSB+BTB_TAG_W-1:TAG_LSB];
    assign w_unused_upd_pc = ^upd_pc;

    // Jumps always resolve taken, whatever the upstream drives
    assign w_upd_taken = upd_taken | ~upd_is_cond;

    // Combinational lookup against the state held before this edge
    always_comb begin
        w_btb_hit   = r_btb_valid[w_pred_btb_idx] && (r_btb_tag[w_pred_btb_idx] == w_pred_tag);
        pred_taken  = w_btb_hit && (r_btb_jump[w_pred_btb_idx] || r_pht[w_pred_pht_idx][CNT_W-1]);
        pred_target = pred_taken ? r_btb_target[w_pred_btb_idx] : pred_pc + XLEN'(4);
        pred_ghr    = r_ghr;
    end

    // Flush request when direction or taken target disagrees with the prediction
    always_comb begin
        mispredict = upd_valid &&
                     ((w_upd_taken != upd_pred_taken) ||
                      (w_upd_taken && (upd_target != upd_pred_target)));
    end

    // Candidate next-history values: speculative shift and recovery load
    generate
        if (GHR_W == 1) begin : g_ghr1
            assign w_ghr_spec    = pred_taken;
            assign w_ghr_recover = w_upd_taken;
        end else begin : g_ghrn
            assign w_ghr_spec    = {r_ghr[GHR_W-2:0], pred_taken};
            assign w_ghr_recover = {upd_ghr[GHR_W-2:0], w_upd_taken};
        end
    endgenerate

    // Global history: recovery beats the same-cycle speculative update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (mispredict) begin
            r_ghr <= w_ghr_recover;
        end else if (pred_valid) begin
            r_ghr <= w_ghr_spec;
        end
    end

    // Saturating counter step for the resolved conditional branch
    always_comb begin
        w_cnt_cur  = r_pht[w_upd_pht_idx];
        w_cnt_next = w_cnt_cur;
        if (w_upd_taken) begin
            if (w_cnt_cur != CNT_MAX) begin
                w_cnt_next = w_cnt_cur + CNT_W'(1);
            end
        end else begin
            if (w_cnt_cur != '0) begin
                w_cnt_next = w_cnt_cur - CNT_W'(1);
            end
        end
    end

    // Pattern history table training
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (upd_valid && upd_is_cond) begin
            r_pht[w_upd_pht_idx] <= w_cnt_next;
        end
    end

    // BTB valid/kind bits: filled on every taken resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btb_valid <= '0;
            r_btb_jump  <= '0;
        end else if (upd_valid && w_upd_taken) begin
            r_btb_valid[w_upd_btb_idx] <= 1'b1;
            r_btb_jump[w_upd_btb_idx]  <= ~upd_is_cond;
        end
    end

    // BTB payload; qualified by the valid bit so it needs no reset
    always_ff @(posedge clk) begin
        if (upd_valid && w_upd_taken) begin
            r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
            r_btb_target[w_upd_btb_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor using a table-level reference model.
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_is_cond;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic [7:0]  upd_ghr;
    logic        mispredict;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_pht [4096];
    bit          m_vld [64];
    bit          m_jmp [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    logic [7:0]  m_ghr;

    gshare_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_ghr(upd_ghr), .mispredict(mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned pidx(input logic [31:0] pc, input logic [7:0] g);
        return ((pc >> 2) % 4096) ^ int'(g);
    endfunction

    function automatic int unsigned bidx(input logic [31:0] pc);
        return (pc >> 2) % 64;
    endfunction

    function automatic int unsigned btag(input logic [31:0] pc);
        return (pc >> 8) % 1024;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) m_pht[i] = 1;
        for (int i = 0; i < 64; i++) begin
            m_vld[i] = 0; m_jmp[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_ghr = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int unsigned b;
        bit hit;
        b   = bidx(pc);
        hit = m_vld[b] && (m_tag[b] == btag(pc));
        t   = hit && (m_jmp[b] || (m_pht[pidx(pc, m_ghr)] >= 2));
        tg  = t ? m_tgt[b] : pc + 32'd4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lookup-only cycle with hand-derived expectations
    task automatic peek(input string tag, input logic [31:0] pc, input bit et,
                        input logic [31:0] etgt, input logic [7:0] eghr);
        pred_valid = 0; upd_valid = 0; pred_pc = pc;
        #1;
        chk({tag, "_taken"},  32'(pred_taken), 32'(et));
        chk({tag, "_target"}, pred_target, etgt);
        chk({tag, "_ghr"},    32'(pred_ghr), 32'(eghr));
        chk({tag, "_mp"},     32'(mispredict), 32'd0);
        @(posedge clk);
        #2;
    endtask

    // One clocked cycle checked against the model, then the model advances
    task automatic step(input bit pv, input logic [31:0] ppc,
                        input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                        input bit ucond, input bit utk, input bit uptk,
                        input logic [31:0] uptgt, input logic [7:0] ughr);
        bit          et, eff, emp;
        logic [31:0] etgt;
        int unsigned i;
        pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_is_cond = ucond;
        upd_taken = utk; upd_pred_taken = uptk; upd_pred_target = uptgt; upd_ghr = ughr;
        #1;
        model_pred(ppc, et, etgt);
        eff = utk | !ucond;
        emp = uv && ((eff != uptk) || (eff && (utgt != uptgt)));
        chk("step_taken",  32'(pred_taken), 32'(et));
        chk("step_target", pred_target, etgt);
        chk("step_ghr",    32'(pred_ghr), 32'(m_ghr));
        chk("step_mp",     32'(mispredict), 32'(emp));
        @(posedge clk);
        if (emp)     m_ghr = {ughr[6:0], eff};
        else if (pv) m_ghr = {m_ghr[6:0], et};
        if (uv && ucond) begin
            i = pidx(upc, ughr);
            if (eff) m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
            else     m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
        end
        if (uv && eff) begin
            i = bidx(upc);
            m_vld[i] = 1; m_jmp[i] = !ucond; m_tag[i] = btag(upc); m_tgt[i] = utgt;
        end
        #2;
        pred_valid = 0; upd_valid = 0;
    endtask

    task automatic rand_step();
        logic [31:0] ppc, upc, utgt, uptgt;
        logic [7:0]  ughr;
        bit          ucond, utk, uptk;
        ppc   = 32'h1000 + ($urandom_range(0, 31) << 2) + (($urandom % 4 == 0) ? 32'h100 : 32'h0);
        upc   = 32'h1000 + ($urandom_range(0, 31) << 2) + (($urandom % 4 == 0) ? 32'h100 : 32'h0);
        ucond = ($urandom % 4) != 0;
        utk   = ucond ? 1'($urandom % 2) : 1'b1;
        case ($urandom % 3)
            0: utgt = 32'h2000;
            1: utgt = 32'h2400;
            default: utgt = upc + 32'd8;
        endcase
        uptk  = ($urandom % 3 == 0) ? ~utk : utk;
        uptgt = ($urandom % 4 == 0) ? 32'h2800 : utgt;
        ughr  = ($urandom % 2 == 0) ? m_ghr : 8'($urandom);
        step(1'($urandom % 2), ppc, 1'($urandom % 2), upc, utgt, ucond, utk, uptk, uptgt, ughr);
    endtask

    initial begin
        rst_n = 0; pred_valid = 0; pred_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_target = 0; upd_is_cond = 0; upd_taken = 0;
        upd_pred_taken = 0; upd_pred_target = 0; upd_ghr = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #2;

        // reset state lookup
        peek("rst", 32'h100, 0, 32'h104, 8'h00);

        // two taken conditional updates train the counter to strongly taken
        step(0, 0, 1, 32'h100, 32'h80, 1, 1, 1, 32'h80, 8'h00);
        step(0, 0, 1, 32'h100, 32'h80, 1, 1, 1, 32'h80, 8'h00);
        peek("trained", 32'h100, 1, 32'h80, 8'h00);

        // four not-taken updates saturate at 0; one taken brings it to 1
        for (int k = 0; k < 4; k++) step(0, 0, 1, 32'h100, 32'h80, 1, 0, 1, 32'h80, 8'h00);
        step(0, 0, 1, 32'h100, 32'h80, 1, 1, 1, 32'h80, 8'h00);
        peek("sat_low", 32'h100, 0, 32'h104, 8'h00);

        // jal at an aliasing BTB index evicts 0x100 and predicts taken regardless of counter
        step(0, 0, 1, 32'h200, 32'h400, 0, 1, 1, 32'h400, 8'h00);
        peek("jal", 32'h200, 1, 32'h400, 8'h00);
        peek("alias", 32'h100, 0, 32'h104, 8'h00);

        // recovery loads history 1011, then recovery beats a taken speculative shift
        step(0, 0, 1, 32'h304, 32'h500, 1, 1, 0, 32'h0, 8'h05);
        peek("ghr_load", 32'h200, 1, 32'h400, 8'h0B);
        step(1, 32'h200, 1, 32'h308, 32'h600, 1, 0, 1, 32'h0, 8'h01);
        peek("ghr_recover", 32'h200, 1, 32'h400, 8'h02);

        // speculative history shift without recovery
        step(1, 32'h200, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        peek("ghr_spec", 32'h100, 0, 32'h104, 8'h05);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) rand_step();

        // short asynchronous reset pulse between clock edges
        rst_n = 0;
        #1;
        rst_n = 1;
        model_reset();
        #1;
        peek("pulse_100", 32'h100, 0, 32'h104, 8'h00);
        peek("pulse_200", 32'h200, 0, 32'h204, 8'h00);
        peek("pulse_1000", 32'h1000, 0, 32'h1004, 8'h00);

        for (int k = 0; k < 200; k++) rand_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter XLEN, default 32: address/data width.
REQ-002 Parameter PHT_IDX_W, default 12: pattern history table (PHT) has 2^PHT_IDX_W counters.
REQ-003 Parameter GHR_W, default 8: global history length; legal range 1..PHT_IDX_W.
REQ-004 Parameter CNT_W, default 2: saturating counter width; legal range 2..4.
REQ-005 Parameter BTB_IDX_W, default 6: BTB has 2^BTB_IDX_W direct-mapped entries.
REQ-006 Parameter BTB_TAG_W, default 10: BTB tag width, taken from pc[BTB_IDX_W+BTB_TAG_W+1 : BTB_IDX_W+2].
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 pred_valid  in  1  IF lookup request this cycle.
REQ-010 pred_pc  in  XLEN  PC of fetched instruction.
REQ-011 pred_taken  out  1  predicted taken.
REQ-012 pred_target  out  XLEN  predicted next PC.
REQ-013 pred_ghr  out  GHR_W  GHR value used for this lookup; carried down the pipe.
REQ-014 upd_valid  in  1  EX resolves a control-transfer instruction this cycle.
REQ-015 upd_pc, upd_target  in  XLEN  resolved PC and actual taken target.
REQ-016 upd_is_cond  in  1  1 = conditional branch, 0 = unconditional jump (jal/jalr).
REQ-017 upd_taken  in  1  actual outcome (forced to 1 when upd_is_cond=0).
REQ-018 upd_pred_taken, upd_pred_target  in  1 / XLEN  prediction made for this instruction.
REQ-019 upd_ghr  in  GHR_W  pred_ghr snapshot returned with the instruction.
REQ-020 mispredict  out  1  flush request to pipeline.

Function
REQ-021 Lookup SHALL be combinational, zero-latency: outputs reflect state before the current edge.
REQ-022 PHT index SHALL be pred_pc[PHT_IDX_W+1:2] XOR zero-extended GHR (GHR in low bits).
REQ-023 BTB hit SHALL require entry valid and stored tag equal to pred_pc tag bits.
REQ-024 pred_taken SHALL be hit AND (entry is_jump OR counter MSB = 1); pred_target SHALL be BTB target if pred_taken, else pred_pc+4 (mod 2^XLEN).
REQ-025 pred_ghr SHALL equal the current GHR register.
REQ-026 On pred_valid with no mispredict, GHR SHALL shift left inserting pred_taken at bit 0 (speculative).
REQ-027 mispredict SHALL be combinational: upd_valid AND (upd_taken != upd_pred_taken OR (upd_taken AND upd_target != upd_pred_target)).
REQ-028 On mispredict, GHR SHALL load {upd_ghr[GHR_W-2:0], upd_taken} (for GHR_W=1: upd_taken); this wins over any same-cycle speculative shift.
REQ-029 On upd_valid with upd_is_cond=1, counter at index upd_pc[PHT_IDX_W+1:2] XOR upd_ghr SHALL increment if taken, else decrement, saturating at 0 and 2^CNT_W-1.
REQ-030 On upd_valid with upd_taken=1, BTB entry at upd_pc index SHALL be written: valid=1, tag, target=upd_target, is_jump=!upd_is_cond.
REQ-031 A not-taken conditional update SHALL NOT modify the BTB.
REQ-032 Same-cycle lookup and update to the same PHT/BTB entry: lookup SHALL return the pre-update value; update SHALL take effect next cycle.
REQ-033 upd_valid=0 SHALL leave PHT and BTB unchanged; pred_valid=0 with no mispredict SHALL leave GHR unchanged.

Reset
REQ-034 While rst_n=0: GHR=0; every counter = 2^(CNT_W-1)-1 (weakly not taken); every BTB valid=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight state immediately; after release, pred_taken=0 and pred_target=pred_pc+4 for every PC until a taken update occurs.
REQ-036 No output SHALL depend on pre-reset history once rst_n rises.

Verification
REQ-037 After reset, pred_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_ghr=0.
REQ-038 Two taken cond updates pc=0x100, target=0x80, upd_ghr=0, then lookup 0x100 with GHR=0 -> pred_taken=1, pred_target=0x80; four further not-taken updates -> counter saturates at 0, then one taken update -> counter 1, pred_taken=0.
REQ-039 jal update pc=0x200, target=0x400 -> next lookup 0x200 pred_taken=1, target=0x400 regardless of counter.
REQ-040 GHR=0b1011 with pred_valid, pred_taken=1 and simultaneous mispredict (upd_ghr=0b0001, upd_taken=0) -> GHR next = 0b0010, mispredict=1.
REQ-041 Aliasing: pc 0x100 and 0x100+(4<<BTB_IDX_W) -> second update evicts first; lookup 0x100 misses, pred_target=0x104.
REQ-042 rst_n pulsed low for 1 ns mid-stream (no clk edge) -> all tables cleared, REQ-037 response holds.
